mem_responder: RTL and testbench

//  Memory-side responder for the multicycle CPU's unified instruction/data memory port.

---
 rtl/mem_responder.sv | 61 ++++++
 tb/tb_mem_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: wait-stated word memory behind the multicycle CPU's unified memory port
module mem_responder #(
  parameter int    DATA_W      = 32,
  parameter int    ADDR_W      = 32,
  parameter int    DEPTH_WORDS = 256,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              mem_err,
  output logic              busy
);
  localparam int IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t            st, nxt;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] d_q;
  logic              we_q, err_c;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  assign idx   = a_q[IW+1:2];
  assign err_c = (a_q[1:0] != 2'b00) || ((a_q >> 2) >= ADDR_W'(DEPTH_WORDS));
  initial for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) st <= S_IDLE;
    else      st <= nxt;
  always_comb
    nxt = st == S_IDLE ? ((MemRead | MemWrite) ? (WAIT_CYCLES > 0 ? S_WAIT : S_RESP) : S_IDLE) :
          st == S_WAIT ? (cnt <= 4'd1 ? S_RESP : S_WAIT) : S_IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      a_q  <= '0;
      d_q  <= '0;
      we_q <= 1'b0;
    end else if (st == S_IDLE && (MemRead | MemWrite)) begin
      cnt  <= 4'(WAIT_CYCLES);
      a_q  <= addr;
      d_q  <= wdata;
      we_q <= MemWrite;
    end else if (st == S_WAIT && cnt != 4'd0) begin
      cnt  <= cnt - 4'd1;
    end
  end
  always_ff @(posedge clk)
    if (st == S_RESP && we_q && !err_c) mem[idx] <= d_q;
  always_comb begin
    mem_ready = st == S_RESP;
    mem_err   = st == S_RESP && err_c;
    busy      = st != S_IDLE;
    rdata     = (st == S_RESP && !err_c) ? mem[idx] : '0;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scenario bench for two mem_responder instances (2 and 0 wait states)
module tb_mem_responder;
    localparam int W0 = 2;
    localparam int W1 = 0;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0]       mr = '0, mw = '0;
    logic [1:0][31:0] ad = '0, wd = '0;
    logic [1:0][31:0] rdat;
    logic [1:0]       rdy, er, bs;

    int errors = 0;
    int checks = 0;
    logic [31:0] mdl [2][DEPTH];

    always #5 clk = ~clk;

    mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0), .INIT_FILE("")) u0 (
        .clk(clk), .rst(rst), .MemRead(mr[0]), .MemWrite(mw[0]), .addr(ad[0]), .wdata(wd[0]),
        .rdata(rdat[0]), .mem_ready(rdy[0]), .mem_err(er[0]), .busy(bs[0]));

    mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1), .INIT_FILE("")) u1 (
        .clk(clk), .rst(rst), .MemRead(mr[1]), .MemWrite(mw[1]), .addr(ad[1]), .wdata(wd[1]),
        .rdata(rdat[1]), .mem_ready(rdy[1]), .mem_err(er[1]), .busy(bs[1]));

    function automatic logic bad_addr(input logic [31:0] a);
        return a[1:0] != 2'b00 || (a >> 2) >= 32'(DEPTH);
    endfunction

    function automatic int lat_of(input int s);
        return 1 + (s == 0 ? W0 : W1);
    endfunction

    // Issue one request, then watch negedges until the response (bounded).
    task automatic acc(input int s, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input bit scr, output int lat, output logic [31:0] rv, output logic ev,
                       output int bad, output logic bsy_after);
        @(negedge clk);
        mr[s] = r; mw[s] = w; ad[s] = a; wd[s] = d;
        lat = 0; bad = 0; rv = 'x; ev = 'x;
        while (lat <= 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                mr[s] = 1'b0; mw[s] = 1'b0;
                if (scr) begin ad[s] = $urandom; wd[s] = $urandom; end
            end
            if (rdy[s] === 1'b1) break;
            if (bs[s] !== 1'b1 || rdat[s] !== 32'h0 || er[s] !== 1'b0) bad++;
        end
        if (lat <= 20) begin rv = rdat[s]; ev = er[s]; end
        @(negedge clk);
        bsy_after = bs[s];
    endtask

    // Run one access and compare everything it produced against the model, then update the model.
    task automatic test_access(input string nm, input int s, input logic r, input logic w,
                               input logic [31:0] a, input logic [31:0] d, input bit scr);
        int lat, bad; logic [31:0] rv, erv; logic ev, ba, e;
        e = bad_addr(a);
        erv = e ? 32'h0 : mdl[s][a[9:2]];
        acc(s, r, w, a, d, scr, lat, rv, ev, bad, ba);
        checks++; if (lat !== lat_of(s)) begin errors++; $display("FAIL %s latency: got %0d want %0d", nm, lat, lat_of(s)); end
        checks++; if (ev !== e) begin errors++; $display("FAIL %s mem_err: got %b want %b", nm, ev, e); end
        checks++; if (rv !== erv) begin errors++; $display("FAIL %s rdata: got %h want %h", nm, rv, erv); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL %s wait-cycle outputs: %0d bad cycles want 0", nm, bad); end
        checks++; if (ba !== 1'b0) begin errors++; $display("FAIL %s busy after resp: got %b want 0", nm, ba); end
        if (w && !e) mdl[s][a[9:2]] = d;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++; if (rdy[s] !== 1'b0) begin errors++; $display("FAIL reset mem_ready[%0d]: got %b want 0", s, rdy[s]); end
            checks++; if (er[s] !== 1'b0) begin errors++; $display("FAIL reset mem_err[%0d]: got %b want 0", s, er[s]); end
            checks++; if (bs[s] !== 1'b0) begin errors++; $display("FAIL reset busy[%0d]: got %b want 0", s, bs[s]); end
            checks++; if (rdat[s] !== 32'h0) begin errors++; $display("FAIL reset rdata[%0d]: got %h want 0", s, rdat[s]); end
        end
        rst = 1'b1;
    endtask

    task automatic test_write_read();
        test_access("wr_0x10", 0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        test_access("rd_0x10", 0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        test_access("wr_0x3fc", 0, 1'b0, 1'b1, 32'h3FC, $urandom, 1'b0);
        test_access("rd_0x3fc", 0, 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0);
        test_access("w0_wr_0x10", 1, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 1'b0);
        test_access("w0_rd_0x10", 1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    endtask

    task automatic test_errors();
        test_access("wr_0x0", 0, 1'b0, 1'b1, 32'h0, $urandom, 1'b0);
        test_access("rd_misalign", 0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
        test_access("wr_oor", 0, 1'b0, 1'b1, 32'h400, 32'h5, 1'b0);
        test_access("wr_highbits", 0, 1'b0, 1'b1, 32'h8000_0010, 32'h12345678, 1'b0);
        test_access("wr_misalign", 0, 1'b0, 1'b1, 32'h3FE, 32'h9, 1'b0);
        test_access("rb_0x0", 0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        test_access("rb_0x3fc", 0, 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0);
        test_access("rb_0x10", 0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        test_access("w0_rd_oor", 1, 1'b1, 1'b0, 32'h404, 32'h0, 1'b0);
    endtask

    task automatic test_read_write_both();
        test_access("both_pre", 0, 1'b0, 1'b1, 32'h8, 32'h11111111, 1'b0);
        test_access("both", 0, 1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 1'b0);
        test_access("both_rb", 0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
    endtask

    task automatic test_hold_change();
        test_access("hold_wr", 0, 1'b0, 1'b1, 32'h44, 32'h0BADC0DE, 1'b1);
        test_access("hold_rd", 0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b1);
        test_access("w0_hold_wr", 1, 1'b0, 1'b1, 32'h48, 32'h600DF00D, 1'b1);
        test_access("w0_hold_rd", 1, 1'b1, 1'b0, 32'h48, 32'h0, 1'b1);
    endtask

    task automatic test_reset_mid();
        test_access("mid_pre", 0, 1'b0, 1'b1, 32'h20, $urandom, 1'b0);
        @(negedge clk);
        mw[0] = 1'b1; ad[0] = 32'h20; wd[0] = 32'h77;
        @(negedge clk);
        mw[0] = 1'b0;
        checks++; if (bs[0] !== 1'b1) begin errors++; $display("FAIL mid busy before reset: got %b want 1", bs[0]); end
        #2 rst = 1'b0;
        #1;
        checks++; if (bs[0] !== 1'b0) begin errors++; $display("FAIL mid busy: got %b want 0", bs[0]); end
        checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL mid mem_ready: got %b want 0", rdy[0]); end
        checks++; if (er[0] !== 1'b0 || rdat[0] !== 32'h0) begin errors++; $display("FAIL mid err/rdata: got %b/%h want 0/0", er[0], rdat[0]); end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (rdy[0] !== 1'b0 || bs[0] !== 1'b0) begin errors++; $display("FAIL mid after: ready/busy %b/%b want 0/0", rdy[0], bs[0]); end
        end
        test_access("mid_rb", 0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    endtask

    // MemRead held high: one response every 2+WAIT_CYCLES cycles.
    task automatic test_back_to_back();
        for (int s = 0; s < 2; s++) begin
            int per, n;
            per = 1 + lat_of(s);
            n = 4 * per;
            test_access("b2b_pre", s, 1'b0, 1'b1, 32'h0, $urandom, 1'b0);
            @(negedge clk);
            mr[s] = 1'b1; ad[s] = 32'h0;
            for (int k = 1; k <= n; k++) begin
                logic exp_r;
                @(negedge clk);
                if (k == n) mr[s] = 1'b0;
                exp_r = (k % per) == lat_of(s) % per;
                checks++; if (rdy[s] !== exp_r) begin errors++; $display("FAIL b2b[%0d] k=%0d mem_ready: got %b want %b", s, k, rdy[s], exp_r); end
                if (exp_r) begin
                    checks++; if (rdat[s] !== mdl[s][0]) begin errors++; $display("FAIL b2b[%0d] rdata: got %h want %h", s, rdat[s], mdl[s][0]); end
                end
            end
            @(negedge clk);
            checks++; if (bs[s] !== 1'b0 || rdy[s] !== 1'b0) begin errors++; $display("FAIL b2b[%0d] stop: busy/ready %b/%b want 0/0", s, bs[s], rdy[s]); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int s, r, op;
            logic [31:0] a;
            s = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            op = $urandom_range(0, 2);
            a = r == 0 ? {22'($urandom), 10'($urandom) | 10'h1} :
                r == 1 ? {20'h0, 10'($urandom_range(256, 1023)), 2'b00} :
                {22'h0, 8'($urandom_range(0, 15)), 2'b00};
            test_access("rand", s, op != 1, op != 0, a, $urandom, $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++) mdl[s][i] = 32'h0;
        test_reset();
        test_write_read();
        test_errors();
        test_read_write_both();
        test_hold_change();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
